// File: rtl/sync_fifo_pkt.sv
// ---------------------------------------------------------------------------
// sync_fifo_pkt
//   Single-clock FIFO with optional first-word-fall-through output and an
//   optional packet mode. In packet mode, written words stay invisible to
//   the reader until the packet's last word is written. A packet that is
//   explicitly dropped, or that lost a word to overflow, is rolled back so
//   the reader never sees a partial packet.
//
// Parameters
//   DATA_WIDTH  word width
//   ADDR_WIDTH  log2 of depth
//   RAM_STYLE   storage hint for synthesis: "block" or "distributed"
//   FWFT_EN     1 = dout shows the head word without a read request
//   PKT_MODE    1 = words commit on wr_last, 0 = every write commits
//
// Ports
//   clk, rst                   clock, asynchronous active-high reset
//   din, wr_en, wr_last,       write side; wr_last/wr_drop used only in
//   wr_drop                    packet mode
//   full, almost_full,         write-side status; wr_count includes
//   wr_count, overflow,        uncommitted words
//   pkt_dropped
//   dout, rd_en, empty,        read side; rd_count includes the word held
//   almost_empty, rd_count,    in the FWFT output register
//   underflow
//   af_thresh, ae_thresh       quasi-static almost-full/almost-empty levels
// ---------------------------------------------------------------------------
module sync_fifo_pkt #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 4,
  parameter string RAM_STYLE  = "distributed",
  parameter bit    FWFT_EN    = 1'b1,
  parameter bit    PKT_MODE   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  // write side
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  wr_last,
  input  logic                  wr_drop,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_count,
  output logic                  overflow,
  output logic                  pkt_dropped,
  // read side
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  rd_en,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  underflow,
  // thresholds
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh
);

  localparam int                DEPTH      = 1 << ADDR_WIDTH;
  localparam int                PW         = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = PW'(1);
  localparam logic [ADDR_WIDTH:0] FULL_CNT = PW'(DEPTH);

  // Storage
  (* ram_style = RAM_STYLE *)
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [ADDR_WIDTH:0]   r_wr_ptr;   // speculative write pointer
  logic [ADDR_WIDTH:0]   r_cm_ptr;   // end of committed data
  logic [ADDR_WIDTH:0]   r_rd_ptr;   // head word (still held while in ov)
  logic                  r_bad_pkt;
  logic                  r_ov;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_pkt_dropped;

  logic [ADDR_WIDTH:0]   w_wr_count;
  logic [ADDR_WIDTH:0]   w_rd_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  logic                  w_mem_we;
  logic                  w_commit;
  logic                  w_rd_accept;
  logic [ADDR_WIDTH:0]   w_fetch_ptr;
  logic                  w_fetch_ok;

  // -------------------------------------------------------------------------
  // Status, all derived from registered state
  // -------------------------------------------------------------------------
  assign w_wr_count = r_wr_ptr - r_rd_ptr;
  assign w_rd_count = r_cm_ptr - r_rd_ptr;
  assign w_full     = (w_wr_count == FULL_CNT);
  // In FWFT mode the reader only sees what sits in the output register.
  assign w_empty    = FWFT_EN ? !r_ov : (r_cm_ptr == r_rd_ptr);

  // -------------------------------------------------------------------------
  // Write-side decisions
  // -------------------------------------------------------------------------
  // A wr_last beat that is itself rejected also ends a damaged packet, so a
  // truncated packet can never merge with the next one.
  assign w_drop   = PKT_MODE &&
                    (wr_drop || (wr_en && wr_last && (r_bad_pkt || w_full)));
  assign w_mem_we = wr_en && !w_full && !w_drop;
  assign w_commit = w_mem_we && (!PKT_MODE || wr_last);

  // -------------------------------------------------------------------------
  // Read-side decisions
  // -------------------------------------------------------------------------
  assign w_rd_accept = rd_en && !w_empty;
  // FWFT: when the shown word is consumed, the next one to fetch sits one
  // past the head; otherwise the head itself is fetched.
  assign w_fetch_ptr = (FWFT_EN && w_rd_accept) ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
  assign w_fetch_ok  = (r_cm_ptr != w_fetch_ptr);

  // NOTE: storage has no reset; pointers alone define which entries are
  // valid, and leaving the array unreset lets it map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= din;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, which is what the pointer
  // comparisons above assume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr      <= '0;
      r_cm_ptr      <= '0;
      r_bad_pkt     <= 1'b0;
      r_overflow    <= 1'b0;
      r_pkt_dropped <= 1'b0;
    end else begin
      r_overflow    <= wr_en && w_full;
      r_pkt_dropped <= w_drop;
      if (w_drop) begin
        // Roll back every uncommitted word, including this beat's.
        r_wr_ptr  <= r_cm_ptr;
        r_bad_pkt <= 1'b0;
      end else begin
        if (w_mem_we) r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_commit) r_cm_ptr <= r_wr_ptr + PTR_ONE;
        if (PKT_MODE && wr_en && w_full) r_bad_pkt <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr    <= '0;
      r_ov        <= 1'b0;
      r_dout      <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_underflow <= rd_en && w_empty;
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (FWFT_EN) begin
        // Refill the output register whenever it is free or being consumed.
        if (!r_ov || w_rd_accept) begin
          r_ov <= w_fetch_ok;
          if (w_fetch_ok) r_dout <= r_mem[w_fetch_ptr[ADDR_WIDTH-1:0]];
        end
      end else begin
        r_ov <= 1'b0;
        if (w_rd_accept) r_dout <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign full         = w_full;
  assign almost_full  = (w_wr_count >= af_thresh);
  assign wr_count     = w_wr_count;
  assign overflow     = r_overflow;
  assign pkt_dropped  = r_pkt_dropped;
  assign dout         = r_dout;
  assign empty        = w_empty;
  assign almost_empty = (w_rd_count <= ae_thresh);
  assign rd_count     = w_rd_count;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_pkt.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_pkt
//   Three instances with DATA_WIDTH=8, ADDR_WIDTH=3 share the data and
//   threshold inputs but have private wr_en/rd_en, so each keeps its own
//   state:  dut 0 = FWFT, stream mode; dut 1 = standard read, stream mode;
//   dut 2 = FWFT, packet mode.
//   A reference queue holds committed words (plus a pending queue for the
//   open packet); read data is popped from it and compared against dout.
// ---------------------------------------------------------------------------
module tb_sync_fifo_pkt;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din;
  logic          wr_last, wr_drop;
  logic [2:0]    wr_en_v, rd_en_v;
  logic [AW:0]   af_thresh, ae_thresh;

  logic [2:0]    full_v, afull_v, ovf_v, drop_v, empty_v, aempty_v, udf_v;
  logic [AW:0]   wrc_v  [3];
  logic [AW:0]   rdc_v  [3];
  logic [DW-1:0] dout_v [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sync_fifo_pkt #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .RAM_STYLE  ("distributed"),
      .FWFT_EN    (g != 1),
      .PKT_MODE   (g == 2)
    ) u_dut (
      .clk          (clk),
      .rst          (rst),
      .din          (din),
      .wr_en        (wr_en_v[g]),
      .wr_last      (wr_last),
      .wr_drop      (wr_drop),
      .full         (full_v[g]),
      .almost_full  (afull_v[g]),
      .wr_count     (wrc_v[g]),
      .overflow     (ovf_v[g]),
      .pkt_dropped  (drop_v[g]),
      .dout         (dout_v[g]),
      .rd_en        (rd_en_v[g]),
      .empty        (empty_v[g]),
      .almost_empty (aempty_v[g]),
      .rd_count     (rdc_v[g]),
      .underflow    (udf_v[g]),
      .af_thresh    (af_thresh),
      .ae_thresh    (ae_thresh)
    );
  end

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] sb   [$];   // committed, unread words (head = next read)
  logic [DW-1:0] pend [$];   // words of the open packet (packet dut only)
  bit            m_bad;

  task automatic clear_model();
    sb.delete();
    pend.delete();
    m_bad = 1'b0;
  endtask

  // One clock: drive inputs for dut d, update the model, advance to 1 time
  // unit after the edge. FWFT data is compared before the edge (word on
  // dout being consumed); standard data is compared after it.
  task automatic cycle(input int d, input logic we, input logic [DW-1:0] di,
                       input logic wl, input logic wd, input logic re);
    logic [DW-1:0] exp_d;
    bit            std_rd;
    bit            m_full;
    bit            drop;
    std_rd  = 1'b0;
    exp_d   = '0;
    din     = di;
    wr_last = wl;
    wr_drop = wd;
    wr_en_v = '0;
    rd_en_v = '0;
    if (we) wr_en_v[d] = 1'b1;
    if (re) rd_en_v[d] = 1'b1;

    m_full = (sb.size() + pend.size()) >= DEPTH;
    if (re && sb.size() > 0) begin
      exp_d = sb.pop_front();
      if (d == 1) std_rd = 1'b1;
      else check($sformatf("dut%0d fwft dout", d), dout_v[d], exp_d);
    end
    if (d == 2) begin
      drop = wd || (we && wl && (m_bad || m_full));
      if (drop) begin
        pend.delete();
        m_bad = 1'b0;
      end else if (we) begin
        if (m_full) m_bad = 1'b1;
        else begin
          pend.push_back(di);
          if (wl) begin
            while (pend.size() > 0) sb.push_back(pend.pop_front());
          end
        end
      end
    end else if (we && !m_full) begin
      sb.push_back(di);
    end

    @(posedge clk);
    #1;
    if (std_rd) check("dut1 std dout", dout_v[1], exp_d);
  endtask

  task automatic idle(input int d);
    cycle(d, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    wr_en_v = '0;
    rd_en_v = '0;
    wr_last = 1'b0;
    wr_drop = 1'b0;
    din     = '0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Vector table: inputs plus expected status after the edge
  // -------------------------------------------------------------------------
  typedef struct {
    int          dut;
    logic        we;
    logic [DW-1:0] di;
    logic        wl, wd, re;
    logic [AW:0] e_wrc, e_rdc;
    logic        e_full, e_empty, e_ovf, e_udf, e_drop;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input int d, input logic we, input logic [DW-1:0] di,
                              input logic wl, input logic wd, input logic re,
                              input logic [AW:0] wrc, input logic [AW:0] rdc,
                              input logic fu, input logic em, input logic of,
                              input logic uf, input logic dr);
    vec_t v;
    v.dut = d;   v.we = we;   v.di = di;   v.wl = wl;   v.wd = wd;   v.re = re;
    v.e_wrc = wrc;  v.e_rdc = rdc;  v.e_full = fu;  v.e_empty = em;
    v.e_ovf = of;   v.e_udf = uf;   v.e_drop = dr;
    return v;
  endfunction

  task automatic build_table();
    // Fill and drain, FWFT stream (dut 0)
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0,
                       4'(i + 1), 4'(i + 1), i == 7, i == 0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 4'd8, 4'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,
                       4'(7 - k), 4'(7 - k), 1'b0, k == 7, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    // Packet commit (dut 2)
    tbl.push_back(mk(2, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0, 4'd3, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,
                       4'(2 - k), 4'(2 - k), 1'b0, k == 2, 1'b0, 1'b0, 1'b0));

    // Packet drop, then a single-word packet
    tbl.push_back(mk(2, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 4'd2, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(2, 1'b1, 8'h66, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));

    // Overflowed packet: 6-word packet commits, 4-word packet loses a word
    for (int i = 0; i < 6; i++)
      tbl.push_back(mk(2, 1'b1, 8'(8'hA0 + i), i == 5, 1'b0, 1'b0,
                       4'(i + 1), (i == 5) ? 4'd6 : 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b0, 4'd7, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b0, 4'd8, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 4'd8, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(2, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b0, 4'd6, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(2, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1,
                       4'(5 - k), 4'(5 - k), 1'b0, k == 5, 1'b0, 1'b0, 1'b0));
  endtask

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    din       = '0;
    wr_last   = 1'b0;
    wr_drop   = 1'b0;
    wr_en_v   = '0;
    rd_en_v   = '0;
    af_thresh = 4'd8;
    ae_thresh = 4'd0;
    clear_model();
    #2;

    // Reset state of every instance
    for (int d = 0; d < 3; d++) begin
      check($sformatf("rst dut%0d empty", d),  empty_v[d],  1'b1);
      check($sformatf("rst dut%0d full", d),   full_v[d],   1'b0);
      check($sformatf("rst dut%0d wr_count", d), wrc_v[d],  4'd0);
      check($sformatf("rst dut%0d rd_count", d), rdc_v[d],  4'd0);
      check($sformatf("rst dut%0d aempty", d), aempty_v[d], 1'b1);
      check($sformatf("rst dut%0d afull", d),  afull_v[d],  1'b0);
      check($sformatf("rst dut%0d dout", d),   dout_v[d],   8'h00);
      check($sformatf("rst dut%0d pulses", d),
            {ovf_v[d], udf_v[d], drop_v[d]}, 3'b000);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven part
    build_table();
    foreach (tbl[i]) begin
      cycle(tbl[i].dut, tbl[i].we, tbl[i].di, tbl[i].wl, tbl[i].wd, tbl[i].re);
      check($sformatf("v%0d wr_count", i), wrc_v[tbl[i].dut],  tbl[i].e_wrc);
      check($sformatf("v%0d rd_count", i), rdc_v[tbl[i].dut],  tbl[i].e_rdc);
      check($sformatf("v%0d full", i),     full_v[tbl[i].dut], tbl[i].e_full);
      check($sformatf("v%0d empty", i),    empty_v[tbl[i].dut], tbl[i].e_empty);
      check($sformatf("v%0d overflow", i), ovf_v[tbl[i].dut],  tbl[i].e_ovf);
      check($sformatf("v%0d underflow", i), udf_v[tbl[i].dut], tbl[i].e_udf);
      check($sformatf("v%0d pkt_dropped", i), drop_v[tbl[i].dut], tbl[i].e_drop);
    end
    check("reference queue drained", sb.size(), 0);

    // Standard read latency (dut 1)
    do_reset();
    cycle(1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);      // edge 1
    check("std empty after write edge", empty_v[1], 1'b0);
    check("std rd_count after write",   rdc_v[1],   4'd1);
    idle(1);                                      // edge 2
    check("std dout before read", dout_v[1], 8'h00);
    cycle(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);      // edge 3
    check("std dout after read edge", dout_v[1], 8'hA5);
    check("std empty after read",     empty_v[1], 1'b1);
    idle(1);
    check("std dout holds", dout_v[1], 8'hA5);

    // Thresholds (dut 0)
    af_thresh = 4'd6;
    ae_thresh = 4'd1;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cycle(0, 1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
      check($sformatf("afull after write %0d", i + 1), afull_v[0], i == 5);
    end
    idle(0);
    for (int k = 0; k < 5; k++) begin
      cycle(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      check($sformatf("rd_count after read %0d", k + 1), rdc_v[0], 4'(5 - k));
      check($sformatf("aempty after read %0d", k + 1), aempty_v[0], k == 4);
    end
    check("afull after reads", afull_v[0], 1'b0);

    // Asynchronous reset in the middle of traffic
    cycle(0, 1'b1, 8'h40, 1'b0, 1'b0, 1'b0);
    cycle(0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    check("pre-reset rd_count", rdc_v[0], 4'd3);
    #2;
    rst     = 1'b1;
    wr_en_v = '0;
    rd_en_v = '0;
    clear_model();
    #1;
    check("mid rst wr_count", wrc_v[0],    4'd0);
    check("mid rst rd_count", rdc_v[0],    4'd0);
    check("mid rst empty",    empty_v[0],  1'b1);
    check("mid rst full",     full_v[0],   1'b0);
    check("mid rst aempty",   aempty_v[0], 1'b1);
    check("mid rst dout",     dout_v[0],   8'h00);
    af_thresh = 4'd0;
    #1;
    check("afull with zero threshold", afull_v[0], 1'b1);
    af_thresh = 4'd8;
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    cycle(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("underflow after reset", udf_v[0], 1'b1);
    check("empty after reset read", empty_v[0], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
